// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment bus capture: glitch filter, decode to BCD, frame handshake.
// Optional SEG7_OVERRUN_EN adds a sticky overrun flag for frames dropped while one is held.
module seg7_scan_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  inv,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     seg_err,
  output logic                  frame_valid,
`ifdef SEG7_OVERRUN_EN
  output logic                  overrun,
`endif
  input  logic                  frame_ack
);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  localparam logic [3:0]        STB  = 4'(STABLE_CNT);
  localparam logic [DIGITS-1:0] ALL  = {DIGITS{1'b1}};
  localparam logic [DIGITS-1:0] ONE  = DIGITS'(1);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   en_q;
  logic                inv_q;
  logic [6:0]          prev_p;
  logic [DIGITS-1:0]   prev_en;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nxt;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_nxt;
  logic [4*DIGITS-1:0] stage_bcd;
  logic [DIGITS-1:0]   stage_err;
  logic                offer;
  state_t              state;
  state_t              state_nxt;

  logic [6:0] p;
  logic       onehot;
  logic       same;
  logic       accept;
  logic       complete;
  logic [4:0] dec;
  logic       load;
  logic       valid_nxt;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h1F;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
      inv_q <= 1'b0;
    end else begin
      seg_q <= seg_in;
      en_q  <= dig_en;
      inv_q <= inv;
    end
  end

  assign p      = inv_q ? ~seg_q : seg_q;
  assign onehot = (en_q != '0) && ((en_q & (en_q - ONE)) == '0);
  assign same   = (p == prev_p) && (en_q == prev_en);
  assign dec    = decode(p);

  always_comb begin
    cnt_nxt = '0;
    if (onehot) begin
      if (same)
        cnt_nxt = (cnt == STB) ? cnt : cnt + 4'd1;
      else
        cnt_nxt = 4'd1;
    end
  end

  // Fires only on the edge the run reaches STB, so a long stable run accepts once.
  assign accept   = onehot && (cnt_nxt == STB) && (cnt != STB);
  assign seen_nxt = seen | (accept ? en_q : '0);
  assign complete = accept && (seen_nxt == ALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p    <= '0;
      prev_en   <= '0;
      cnt       <= '0;
      seen      <= '0;
      stage_bcd <= '0;
      stage_err <= '0;
      offer     <= 1'b0;
    end else begin
      prev_p  <= p;
      prev_en <= en_q;
      cnt     <= cnt_nxt;
      seen    <= complete ? '0 : seen_nxt;
      offer   <= complete;
      for (int i = 0; i < DIGITS; i++) begin
        if (accept && en_q[i]) begin
          stage_bcd[4*i +: 4] <= dec[3:0];
          stage_err[i]        <= dec[4];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    valid_nxt = frame_valid;
    unique case (state)
      COLLECT: begin
        if (offer) begin
          load      = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          if (offer) begin
            load = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = COLLECT;
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      frame_valid <= 1'b0;
      bcd_out     <= '0;
      seg_err     <= '0;
    end else begin
      state       <= state_nxt;
      frame_valid <= valid_nxt;
      if (load) begin
        bcd_out <= stage_bcd;
        seg_err <= stage_err;
      end
    end
  end

`ifdef SEG7_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (state == HOLD && frame_ack)
      overrun <= 1'b0;
    else if (state == HOLD && offer)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (DIGITS=4, STABLE_CNT=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_seg7_scan_capture;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic        inv;
  logic [15:0] bcd_out;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        frame_ack;
`ifdef SEG7_OVERRUN_EN
  logic        overrun;
`endif

  int checks;
  int failures;

  seg7_scan_capture #(
    .DIGITS(4),
    .STABLE_CNT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .dig_en(dig_en),
    .inv(inv),
    .bcd_out(bcd_out),
    .seg_err(seg_err),
    .frame_valid(frame_valid),
`ifdef SEG7_OVERRUN_EN
    .overrun(overrun),
`endif
    .frame_ack(frame_ack)
  );

  always #5 clk = ~clk;

  task automatic scan(input logic [6:0] s, input logic [3:0] en, input int n);
    seg_in = inv ? ~s : s;
    dig_en = en;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    seg_in = '0;
    dig_en = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, s1, s2, s3);
    scan(s0, 4'b0001, 4);
    scan(s1, 4'b0010, 4);
    scan(s2, 4'b0100, 4);
    scan(s3, 4'b1000, 4);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bcd_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_bcd got=%h exp=%h", bcd_out, 16'h0);
    end
    checks++;
    if (seg_err !== 4'h0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b/%b exp=0000/0", seg_err, frame_valid);
    end
`ifdef SEG7_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_overrun got=%b exp=0", overrun);
    end
`endif
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_decode();
    scan(P3, 4'b0001, 4);
    scan(P4, 4'b0010, 4);
    scan(P5, 4'b0100, 4);
    scan(P6, 4'b1000, 4);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got=%b exp=0", frame_valid);
    end
    idle(1);
    checks++;
    if (frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_edge got=%b exp=1", frame_valid);
    end
    checks++;
    if (bcd_out !== 16'h6543) begin
      failures++;
      $display("FAIL decode_bcd got=%h exp=%h", bcd_out, 16'h6543);
    end
    checks++;
    if (seg_err !== 4'b0000) begin
      failures++;
      $display("FAIL decode_err got=%b exp=0000", seg_err);
    end
    idle(2);
    pulse_ack();
    checks++;
    if (frame_valid !== 1'b0 || bcd_out !== 16'h6543) begin
      failures++;
      $display("FAIL ack_release got=%b/%h exp=0/6543", frame_valid, bcd_out);
    end
  endtask

  task automatic test_invert();
    inv = 1'b1;
    idle(2);
    frame(P3, P4, P5, P6);
    idle(2);
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h6543) begin
      failures++;
      $display("FAIL invert_bcd got=%b/%h exp=1/6543", frame_valid, bcd_out);
    end
    pulse_ack();
    inv = 1'b0;
    idle(2);
    frame(P0, P1, 7'b0000001, P8);
    idle(2);
    checks++;
    if (bcd_out !== 16'h8F10) begin
      failures++;
      $display("FAIL illegal_bcd got=%h exp=%h", bcd_out, 16'h8F10);
    end
    checks++;
    if (seg_err !== 4'b0100) begin
      failures++;
      $display("FAIL illegal_err got=%b exp=0100", seg_err);
    end
    pulse_ack();
  endtask

  task automatic test_glitch();
    scan(P3, 4'b0001, 4);
    scan(P5, 4'b0100, 4);
    scan(P6, 4'b1000, 4);
    scan(P0, 4'b0011, 5);
    idle(3);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL nonhot_accept got=%b exp=0", frame_valid);
    end
    scan(P0, 4'b0010, 2);
    scan(P1, 4'b0010, 3);
    idle(2);
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h6513) begin
      failures++;
      $display("FAIL glitch_bcd got=%b/%h exp=1/6513", frame_valid, bcd_out);
    end
    checks++;
    if (seg_err !== 4'b0000) begin
      failures++;
      $display("FAIL glitch_err got=%b exp=0000", seg_err);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    frame(P3, P4, P5, P6);
    idle(2);
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h6543) begin
      failures++;
      $display("FAIL b2b_first got=%b/%h exp=1/6543", frame_valid, bcd_out);
    end
    frame(P0, P1, P2, P3);
    idle(2);
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h6543) begin
      failures++;
      $display("FAIL b2b_hold got=%b/%h exp=1/6543", frame_valid, bcd_out);
    end
`ifdef SEG7_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun);
    end
`endif
    scan(P7, 4'b0001, 4);
    scan(P8, 4'b0010, 4);
    scan(P9, 4'b0100, 4);
    scan(P2, 4'b1000, 4);
    frame_ack = 1'b1;
    idle(1);
    frame_ack = 1'b0;
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h2987) begin
      failures++;
      $display("FAIL ack_load got=%b/%h exp=1/2987", frame_valid, bcd_out);
    end
`ifdef SEG7_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr got=%b exp=0", overrun);
    end
`endif
    pulse_ack();
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release got=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_reset_mid();
    scan(P1, 4'b0001, 4);
    scan(P2, 4'b0010, 4);
    idle(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 16'h0 || seg_err !== 4'h0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out got=%h/%b/%b exp=0/0/0",
               bcd_out, seg_err, frame_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    scan(P3, 4'b0100, 4);
    scan(P4, 4'b1000, 4);
    idle(3);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_partial got=%b exp=0", frame_valid);
    end
    scan(P5, 4'b0001, 4);
    scan(P6, 4'b0010, 4);
    idle(2);
    checks++;
    if (frame_valid !== 1'b1 || bcd_out !== 16'h4365) begin
      failures++;
      $display("FAIL midreset_recover got=%b/%h exp=1/4365",
               frame_valid, bcd_out);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    seg_in    = '0;
    dig_en    = '0;
    inv       = 1'b0;
    frame_ack = 1'b0;
    test_reset();
    test_decode();
    test_invert();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
